branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 133 +++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Gshare branch direction predictor: PC-xor-history indexed 2-bit counters with
// speculative global history, commit-time training/repair and saturating statistics.
module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_valid,
  input  logic                  fetch_is_branch,
  input  logic [31:0]           fetch_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  output logic [INDEX_BITS-1:0] pred_ghr,
  input  logic                  commit_valid,
  input  logic                  committed_is_branch,
  input  logic                  commit_taken,
  input  logic                  commit_result,
  input  logic [INDEX_BITS-1:0] commit_index,
  input  logic [INDEX_BITS-1:0] commit_ghr,
  output logic                  mispredict_out,
  output logic [15:0]           branch_count,
  output logic [15:0]           mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            r_pht [ENTRIES];
  logic [INDEX_BITS-1:0] r_spec_ghr;
  logic                  r_pred_valid;
  logic                  r_pred_taken;
  logic [INDEX_BITS-1:0] r_pred_index;
  logic [INDEX_BITS-1:0] r_pred_ghr;
  logic [15:0]           r_branch_count;
  logic [15:0]           r_mispredict_count;

  logic                  w_lookup;
  logic                  w_train;
  logic                  w_mispredict;
  logic [INDEX_BITS-1:0] w_index;
  logic [1:0]            w_lookup_ctr;
  logic                  w_pred_bit;
  logic [1:0]            w_train_ctr;
  logic [1:0]            w_train_ctr_nxt;
  logic [INDEX_BITS:0]   w_ghr_shift;
  logic [INDEX_BITS:0]   w_ghr_restore;
  logic                  w_unused_bits;

  assign w_lookup     = fetch_valid & fetch_is_branch;
  assign w_train      = commit_valid & committed_is_branch;
  assign w_mispredict = w_train & (commit_taken ^ commit_result);

  assign w_index      = fetch_pc[INDEX_BITS+1:2] ^ r_spec_ghr;
  assign w_lookup_ctr = r_pht[w_index];
  assign w_pred_bit   = w_lookup_ctr[1];

  assign w_train_ctr  = r_pht[commit_index];

  always_comb begin
    w_train_ctr_nxt = w_train_ctr;
    if (commit_result) begin
      if (w_train_ctr != 2'b11) w_train_ctr_nxt = w_train_ctr + 2'b01;
    end else begin
      if (w_train_ctr != 2'b00) w_train_ctr_nxt = w_train_ctr - 2'b01;
    end
  end

  // Both history updates are formed one bit wide and truncated so the
  // expressions stay legal for any INDEX_BITS >= 1.
  assign w_ghr_shift   = {r_spec_ghr, w_pred_bit};
  assign w_ghr_restore = {commit_ghr, commit_result};

  assign w_unused_bits = ^{fetch_pc[31:INDEX_BITS+2], fetch_pc[1:0],
                           w_ghr_shift[INDEX_BITS], w_ghr_restore[INDEX_BITS]};

  // The lookup above reads the pre-update counter; a same-cycle write to the
  // same entry still lands because it is applied here on the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_pht[i] <= 2'b01;
      end
    end else if (w_train) begin
      r_pht[commit_index] <= w_train_ctr_nxt;
    end
  end

  // pred_valid is a one-cycle strobe with no backpressure: when high,
  // pred_taken/pred_index/pred_ghr describe the branch fetched the cycle before.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_spec_ghr   <= '0;
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_index <= '0;
      r_pred_ghr   <= '0;
    end else if (w_mispredict) begin
      r_spec_ghr   <= w_ghr_restore[INDEX_BITS-1:0];
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
    end else if (w_lookup) begin
      r_spec_ghr   <= w_ghr_shift[INDEX_BITS-1:0];
      r_pred_valid <= 1'b1;
      r_pred_taken <= w_pred_bit;
      r_pred_index <= w_index;
      r_pred_ghr   <= r_spec_ghr;
    end else begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_train) begin
      if (r_branch_count != 16'hFFFF) r_branch_count <= r_branch_count + 16'd1;
      if (w_mispredict && (r_mispredict_count != 16'hFFFF)) begin
        r_mispredict_count <= r_mispredict_count + 16'd1;
      end
    end
  end

  assign pred_valid       = r_pred_valid;
  assign pred_taken       = r_pred_taken;
  assign pred_index       = r_pred_index;
  assign pred_ghr         = r_pred_ghr;
  assign mispredict_out   = w_mispredict;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule
